// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice per cycle, LSB nibble first, carry registered.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_out_q, c_out_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [3:0]        a_nib, b_nib;
    logic [4:0]        slice_res;
    logic              last_nib;

    // Nibble select for the slice operands; only constant part-selects are used.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // The 4-bit slice: the only carry chain in the design, cut by carry_q every cycle.
    always_comb begin
        slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    end

    assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[4*i +: 4] = slice_res[3:0];
                    end
                end
                carry_d = slice_res[4];
                if (last_nib) begin
                    c_out_d = slice_res[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_res[3] != a_q[WIDTH-1]);
`endif
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): transaction-level model plus directed vectors.
module tb_nibble_serial_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         c_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] exact_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return (s > 32767) || (s < -32768);
    endfunction
`endif

    // Transaction model: accept, fixed NIB-cycle latency, hold result until handshake.
    logic         m_in_ready, m_out_valid, m_cout;
    logic [W-1:0] m_sum;
    logic [W:0]   m_pend;
    int           m_cnt;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic         m_ovf, m_pend_ovf;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_ready  <= 1'b1;
            m_out_valid <= 1'b0;
            m_sum       <= '0;
            m_cout      <= 1'b0;
            m_pend      <= '0;
            m_cnt       <= 0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            m_ovf       <= 1'b0;
            m_pend_ovf  <= 1'b0;
`endif
        end else if (m_in_ready) begin
            if (in_valid) begin
                m_in_ready <= 1'b0;
                m_cnt      <= NIB;
                m_pend     <= exact_sum(a, b, c_in);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                m_pend_ovf <= signed_ovf(a, b, c_in);
`endif
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_out_valid <= 1'b1;
                m_sum       <= m_pend[W-1:0];
                m_cout      <= m_pend[W];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                m_ovf       <= m_pend_ovf;
`endif
            end
        end else if (m_out_valid && out_ready) begin
            m_out_valid <= 1'b0;
            m_in_ready  <= 1'b1;
        end
    end

    // Sum is partial while the slice is working, so it is only compared outside that window.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model in_ready", 32'(in_ready), 32'(m_in_ready));
            chk("model out_valid", 32'(out_valid), 32'(m_out_valid));
            chk("model c_out", 32'(c_out), 32'(m_cout));
            if (m_cnt == 0) chk("model sum", 32'(sum), 32'(m_sum));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            chk("model ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic keep_valid, output time t_acc);
        int n;
        in_valid = 1'b1;
        a = x;
        b = y;
        c_in = ci;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: in_ready 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        in_valid = keep_valid;
        a = ~x;
        b = ~y;
        c_in = ~ci;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic get(input string name, input logic [W-1:0] exp_sum, input logic exp_c);
        wait_valid();
        chk({name, " sum"}, 32'(sum), 32'(exp_sum));
        chk({name, " c_out"}, 32'(c_out), 32'(exp_c));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        time t0, t1, t2, tx;
        #1 rst = 1'b1;
        check_en = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset c_out", 32'(c_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, tx);
        chk("busy in_ready", 32'(in_ready), 32'd0);
        get("basic", 16'h2233, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, tx);
        get("full carry", 16'h0000, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, tx);
        get("c_in only", 16'h0001, 1'b0);

        // Backpressure: result held, in_valid pulses ignored.
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, tx);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2) == 0;
            a = 16'(i * 16'h1357);
            b = 16'(i * 16'h2468);
            @(negedge clk);
        end
        in_valid = 1'b0;
        get("backpressure", 16'hBCDE, 1'b0);
        send(16'h0102, 16'h0304, 1'b0, 1'b0, tx);
        get("after backpressure", 16'h0406, 1'b0);

        // Reset after two nibbles of a transaction.
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, tx);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midadd rst sum", 32'(sum), 32'd0);
        chk("midadd rst in_ready", 32'(in_ready), 32'd1);
        chk("midadd rst out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no valid after rst", 32'(out_valid), 32'd0);
        end
        send(16'h0001, 16'h0001, 1'b0, 1'b0, tx);
        get("after rst", 16'h0002, 1'b0);

        // Back-to-back with in_valid held and out_ready high.
        out_ready = 1'b1;
        send(16'h1111, 16'h2222, 1'b1, 1'b1, t0);
        send(16'h8000, 16'h8001, 1'b0, 1'b1, t1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, t2);
        chk("b2b spacing 0-1", 32'(t1 - t0), 32'd60);
        chk("b2b spacing 1-2", 32'(t2 - t1), 32'd60);
        for (int i = 0; i < 8; i++) @(negedge clk);
        out_ready = 1'b0;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, tx);
        wait_valid();
        chk("ovf pos", 32'(ovf), 32'd1);
        get("ovf pos", 16'h8000, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, tx);
        wait_valid();
        chk("ovf neg", 32'(ovf), 32'd1);
        get("ovf neg", 16'h0000, 1'b1);
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, tx);
        wait_valid();
        chk("ovf none", 32'(ovf), 32'd0);
        get("ovf none", 16'h2233, 1'b0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
